// File: rtl/bf_param_stack.sv
// bf_param_stack: parametrised LIFO of loop return addresses.
// The decoder pushes on '[' and pops on ']'. The PC mux consumes the registered top.
// Push and pop in the same cycle replaces the top entry.
// Storage is a circular buffer. A base pointer marks the oldest entry, so that an
// unguarded push while full can overwrite the oldest entry without shifting.
// Optional feature macro: BF_STACK_GUARD_EN.
//   defined   - push while full is ignored and sets a sticky overflow flag;
//               pop while empty sets a sticky underflow flag.
//   undefined - push while full overwrites the oldest entry; both flags read 0.
module bf_param_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         pushd,
  input  logic                     push_en,
  input  logic                     pop_en,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]      CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]      CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]      CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]    IDX_ONE  = AW'(1'b1);
  localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    base_r;
  logic [AW-1:0]    base_s;
  logic [AW:0]      count_r;
  logic [AW:0]      count_s;
  logic [WIDTH-1:0] top_r;
  logic [WIDTH-1:0] top_s;
  logic             empty_r;
  logic             full_r;
  logic             is_empty_s;
  logic             is_full_s;
  logic             wr_en_s;
  logic [AW-1:0]    wr_idx_s;
  logic [AW-1:0]    tail_s;   // physical index of the current top entry
  logic [AW-1:0]    below_s;  // physical index of the entry under the top

`ifdef BF_STACK_GUARD_EN
  logic overflow_r;
  logic underflow_r;
  logic ovf_set_s;
  logic unf_set_s;
`endif

  assign is_empty_s = (count_r == CNT_ZERO);
  assign is_full_s  = (count_r == CNT_FULL);
  // When full, the low count bits are zero, so tail wraps to base-1 (the newest entry).
  assign tail_s     = base_r + count_r[AW-1:0] - IDX_ONE;
  assign below_s    = tail_s - IDX_ONE;

  // Next-state decode for count, base pointer, top register, array write and flags.
  always_comb begin
    count_s  = count_r;
    base_s   = base_r;
    top_s    = top_r;
    wr_en_s  = 1'b0;
    wr_idx_s = tail_s + IDX_ONE;
`ifdef BF_STACK_GUARD_EN
    ovf_set_s = 1'b0;
    unf_set_s = 1'b0;
`endif
    case ({push_en, pop_en})
      2'b10: begin
        if (!is_full_s) begin
          wr_en_s  = 1'b1;
          wr_idx_s = tail_s + IDX_ONE;
          count_s  = count_r + CNT_ONE;
          top_s    = pushd;
        end else begin
`ifdef BF_STACK_GUARD_EN
          ovf_set_s = 1'b1;
`else
          // The oldest slot (base) becomes the newest one; the window slides up by one.
          wr_en_s  = 1'b1;
          wr_idx_s = base_r;
          base_s   = base_r + IDX_ONE;
          top_s    = pushd;
`endif
        end
      end
      2'b01: begin
        if (!is_empty_s) begin
          count_s = count_r - CNT_ONE;
          if (count_r > CNT_ONE) begin
            top_s = mem_r[below_s];
          end else begin
            top_s = DATA_ZERO;
          end
        end else begin
`ifdef BF_STACK_GUARD_EN
          unf_set_s = 1'b1;
`endif
          top_s = DATA_ZERO;
        end
      end
      2'b11: begin
        wr_en_s = 1'b1;
        top_s   = pushd;
        if (is_empty_s) begin
          wr_idx_s = base_r;
          count_s  = CNT_ONE;
        end else begin
          wr_idx_s = tail_s;
        end
      end
      default: begin
        count_s = count_r;
      end
    endcase
  end

  // Control/status registers: count, base pointer, registered top and empty/full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= CNT_ZERO;
      base_r  <= {AW{1'b0}};
      top_r   <= DATA_ZERO;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      count_r <= count_s;
      base_r  <= base_s;
      top_r   <= top_s;
      empty_r <= (count_s == CNT_ZERO);
      full_r  <= (count_s == CNT_FULL);
    end
  end

  // Storage array write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_idx_s] <= pushd;
    end
  end

`ifdef BF_STACK_GUARD_EN
  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= overflow_r | ovf_set_s;
      underflow_r <= underflow_r | unf_set_s;
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign top   = top_r;
  assign count = count_r;
  assign empty = empty_r;
  assign full  = full_r;

endmodule

// File: tb/tb_bf_param_stack.sv
// Testbench for bf_param_stack (WIDTH=16, DEPTH=4). It runs directed scenarios and
// then a randomized run. Each step is checked against a queue-based LIFO model.
// Expectations follow BF_STACK_GUARD_EN in the same way as the design.
module tb_bf_param_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic              clk;
  logic              rst;
  logic [WIDTH-1:0]  pushd;
  logic              push_en;
  logic              pop_en;
  logic [WIDTH-1:0]  top;
  logic [2:0]        count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  int errors = 0;
  int checks = 0;

  // reference model: a plain LIFO with sticky flags
  logic [WIDTH-1:0] q[$];
  logic m_ovf;
  logic m_unf;

  bf_param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pushd(pushd), .push_en(push_en), .pop_en(pop_en),
    .top(top), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_op(input logic p, input logic o, input logic [WIDTH-1:0] d);
    if (p && o) begin
      if (q.size() == 0) q.push_back(d);
      else q[q.size()-1] = d;
    end else if (p) begin
      if (q.size() < DEPTH) q.push_back(d);
      else begin
`ifdef BF_STACK_GUARD_EN
        m_ovf = 1'b1;
`else
        void'(q.pop_front());
        q.push_back(d);
`endif
      end
    end else if (o) begin
      if (q.size() > 0) void'(q.pop_back());
      else begin
`ifdef BF_STACK_GUARD_EN
        m_unf = 1'b1;
`endif
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [WIDTH-1:0] et;
    et = (q.size() == 0) ? 16'h0000 : q[q.size()-1];
    chk({tag, "_top"},   32'(top),       32'(et));
    chk({tag, "_count"}, 32'(count),     32'(q.size()));
    chk({tag, "_empty"}, 32'(empty),     32'(q.size() == 0));
    chk({tag, "_full"},  32'(full),      32'(q.size() == DEPTH));
    chk({tag, "_ovf"},   32'(overflow),  32'(m_ovf));
    chk({tag, "_unf"},   32'(underflow), 32'(m_unf));
  endtask

  task automatic step(input string tag, input logic p, input logic o, input logic [WIDTH-1:0] d);
    @(negedge clk);
    push_en = p;
    pop_en  = o;
    pushd   = d;
    @(posedge clk);
    model_op(p, o, d);
    #1;
    push_en = 1'b0;
    pop_en  = 1'b0;
    check_all(tag);
  endtask

  // asynchronous reset pulse entirely between two rising edges
  task automatic rst_pulse(input string tag);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_all(tag);
    #1 rst = 1'b1;
  endtask

  initial begin
    int op;
    rst = 1'b0;
    push_en = 1'b0;
    pop_en = 1'b0;
    pushd = 16'h0000;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) rst = 1'b1;

    // scenario 1
    step("s1_push_beef", 1'b1, 1'b0, 16'hBEEF);
    step("s1_push_dead", 1'b1, 1'b0, 16'hDEAD);
    chk("s1_top_dead", 32'(top), 32'h0000DEAD);
    step("s1_pop1", 1'b0, 1'b1, 16'h0000);
    chk("s1_top_beef", 32'(top), 32'h0000BEEF);
    step("s1_pop2", 1'b0, 1'b1, 16'h0000);

    // scenario 2
    for (int i = 1; i <= 4; i++) step("s2_fill", 1'b1, 1'b0, 16'(i));
    chk("s2_full", 32'(full), 32'd1);
    step("s2_replace_full", 1'b1, 1'b1, 16'h00AA);
    chk("s2_top_aa", 32'(top), 32'h000000AA);
    step("s2_pop", 1'b0, 1'b1, 16'h0000);
    chk("s2_top_3", 32'(top), 32'h00000003);

    // scenarios 3/4: push while full
    rst_pulse("s3_rst");
    for (int i = 1; i <= 4; i++) step("s3_fill", 1'b1, 1'b0, 16'(i));
    step("s3_push_full", 1'b1, 1'b0, 16'h0005);
`ifdef BF_STACK_GUARD_EN
    chk("s3_top_guard", 32'(top), 32'h00000004);
    chk("s3_ovf_guard", 32'(overflow), 32'd1);
`else
    chk("s3_top_wrap", 32'(top), 32'h00000005);
    chk("s3_ovf_wrap", 32'(overflow), 32'd0);
`endif
    for (int i = 0; i < 4; i++) step("s3_drain", 1'b0, 1'b1, 16'h0000);

    // scenario 5: pop on empty, then push+pop on empty
    step("s5_pop_empty", 1'b0, 1'b1, 16'h0000);
    step("s5_pp_empty", 1'b1, 1'b1, 16'h1234);
    chk("s5_top_1234", 32'(top), 32'h00001234);

    // scenario 6: async reset between edges
    rst_pulse("s6_rst_pre");
    step("s6_push11", 1'b1, 1'b0, 16'h0011);
    step("s6_push22", 1'b1, 1'b0, 16'h0022);
    rst_pulse("s6_rst");
    step("s6_push33", 1'b1, 1'b0, 16'h0033);

    // randomized run, biased so full and empty both occur often
    for (int n = 0; n < 300; n++) begin
      op = int'($urandom_range(0, 99));
      if (op < 2) rst_pulse("rnd_rst");
      else if (op < 45) step("rnd_push", 1'b1, 1'b0, 16'($urandom));
      else if (op < 80) step("rnd_pop", 1'b0, 1'b1, 16'($urandom));
      else if (op < 92) step("rnd_both", 1'b1, 1'b1, 16'($urandom));
      else step("rnd_idle", 1'b0, 1'b0, 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
